pipelined_bus_mux: RTL and testbench
====================================

Name: pipelined_bus_mux

Overview:
- Parametrised, registered successor to the 24-source one-hot datapath bus.
- Selects one of N_SRC WIDTH-bit sources using a one-hot select vector. Registers the result onto the bus with one cycle of latency.
- Reports the encoded source index and detects illegal select patterns (multi-hot or none). Keeps a saturating conflict count and a sticky fault state for CPU debug.
- Sits between the register file / special registers and the ALU / MDR inputs.

Parameters:
- WIDTH, 32, data width of every source and of the bus.
- N_SRC, 24, number of bus sources (range 2..64).
- IDX_W, 6, width of the encoded index; must satisfy 2**IDX_W >= N_SRC.
- CNT_W, 8, width of the conflict counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous active-high reset.
- sel  in  N_SRC  one-hot source select; bit i drives source i.
- data_in  in  N_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- fault_clr  in  1  clears the sticky fault state and the conflict counter.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_out was driven by exactly one source in the previous cycle.
- src_idx  out  IDX_W  registered index of the driving source.
- conflict  out  1  previous cycle's sel had two or more bits set.
- fault  out  1  sticky flag: a conflict has occurred since the last clear or fault_clr.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (clear=1 at a clock edge): bus_out=0, bus_valid=0, src_idx=0, conflict=0, fault=0, conflict_cnt=0, state=NORMAL. clear has priority over every other input.
- Latency: exactly 1 cycle. Values sampled at edge k appear on the outputs after edge k and remain until edge k+1.
- Legal select (popcount(sel)==1, bit i set):
  - bus_out <= source i, src_idx <= i, bus_valid <= 1, conflict <= 0.
- Multi-hot select (popcount >= 2):
  - Lowest set index wins (priority encoder): bus_out and src_idx take that source.
  - bus_valid <= 0, conflict <= 1.
  - conflict_cnt increments by 1 and saturates at 2**CNT_W-1 (no wrap).
  - State goes to FAULT.
- Zero select (sel==0):
  - bus_valid <= 0, conflict <= 0, src_idx unchanged.
  - bus_out is governed by the Optional Feature.
- State machine, 2 states:
  - NORMAL -> FAULT on any multi-hot cycle.
  - FAULT -> NORMAL only on fault_clr=1 in a cycle whose sel is not multi-hot.
  - fault=1 exactly while state==FAULT.
- fault_clr behaviour:
  - fault_clr=1 zeroes conflict_cnt.
  - If the same cycle is multi-hot, the counter loads 1 and the state stays or goes to FAULT: the new event wins over the clear.
- Sources with index >= N_SRC do not exist. data_in has exactly N_SRC slices; there is no padding.
- No combinational path from sel or data_in to any output.

Optional Feature:
- Macro BUS_HOLD_EN.
- Defined: on sel==0, bus_out keeps its previous value (bus keeper), so downstream registers can latch one cycle late.
- Undefined: on sel==0, bus_out <= 0 for that cycle.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package bus_pkg:
  - default WIDTH/N_SRC constants;
  - state enum, NORMAL=1'b0, FAULT=1'b1;
  - function computing IDX_W from N_SRC.
- One natural sub-module: onehot_prio_encoder, purely combinational. Inputs sel; outputs index, any, multi.
- The top level holds the registers, the counter and the FSM.

Test Plan:
- Source i has value 32'hA000_0000+i. For i=0..23 apply sel=1<<i -> next cycle bus_out=32'hA000_0000+i, src_idx=i, bus_valid=1, conflict=0.
- sel=24'h000014 (bits 2 and 4) -> bus_out=32'hA000_0002, src_idx=2, bus_valid=0, conflict=1, fault=1, conflict_cnt=1.
- Apply multi-hot sel for 300 consecutive cycles with CNT_W=8 -> conflict_cnt stops at 255; then one fault_clr with sel=1<<5 -> conflict_cnt=0, fault=0, bus_out=32'hA000_0005.
- sel=1<<7, then sel=0:
  - with BUS_HOLD_EN -> bus_out stays 32'hA000_0007, bus_valid=0;
  - without BUS_HOLD_EN -> bus_out=0.
- Assert clear during a multi-hot cycle with fault=1 -> after the edge all outputs are 0 and state is NORMAL; the next legal sel=1<<3 drives 32'hA000_0003.
- Re-instantiate with N_SRC=8, WIDTH=16, IDX_W=3; walk the one-hot selects -> each 16-bit source appears with src_idx 0..7.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, FSM state type and index-width helper for the bus mux
package bus_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N_SRC = 24;

  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } state_t;

  // Smallest encoded-index width able to name every source.
  function automatic int idx_width(input int n_src);
    return (n_src <= 2) ? 1 : $clog2(n_src);
  endfunction

endpackage

// File: rtl/onehot_prio_encoder.sv
// rtl/onehot_prio_encoder.sv - combinational lowest-index priority encoder with any/multi-hot detect
module onehot_prio_encoder #(
  parameter int N_SRC = 24,
  parameter int IDX_W = 6
) (
  input  logic [N_SRC-1:0] sel,
  output logic [IDX_W-1:0] index,
  output logic             any,
  output logic             multi
);

  always_comb begin
    index = '0;
    // Scan downward so the lowest set bit is the last (winning) assignment.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (sel[i]) index = IDX_W'(i);
    end
    any   = |sel;
    multi = (sel & (sel - N_SRC'(1))) != '0;
  end

endmodule

// File: rtl/pipelined_bus_mux.sv
// rtl/pipelined_bus_mux.sv - registered one-hot bus mux with conflict counter and sticky fault
// Optional bus keeper on empty select: define BUS_HOLD_EN.
module pipelined_bus_mux
  import bus_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_SRC = DEFAULT_N_SRC,
  parameter int IDX_W = 6,
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [N_SRC-1:0]   sel,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  input  logic               fault_clr,
  output logic [WIDTH-1:0]   bus_out,
  output logic               bus_valid,
  output logic [IDX_W-1:0]   src_idx,
  output logic               conflict,
  output logic               fault,
  output logic [CNT_W-1:0]   conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_multi;
  logic [WIDTH-1:0] sel_data;
  state_t           state;
  state_t           state_nxt;

  onehot_prio_encoder #(
    .N_SRC(N_SRC),
    .IDX_W(IDX_W)
  ) u_enc (
    .sel  (sel),
    .index(enc_idx),
    .any  (enc_any),
    .multi(enc_multi)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (enc_idx == IDX_W'(i)) sel_data = data_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) state <= NORMAL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (enc_multi) state_nxt = FAULT;
      FAULT:   if (fault_clr && !enc_multi) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  assign fault = (state == FAULT);

  always_ff @(posedge clock) begin
    if (clear) begin
      bus_out      <= '0;
      bus_valid    <= 1'b0;
      src_idx      <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      bus_valid <= enc_any && !enc_multi;
      conflict  <= enc_multi;
      if (enc_any) begin
        bus_out <= sel_data;
        src_idx <= enc_idx;
      end else begin
`ifdef BUS_HOLD_EN
        bus_out <= bus_out;
`else
        bus_out <= '0;
`endif
      end
      // A conflict in the same cycle as fault_clr counts as the first new event.
      if (enc_multi) begin
        if (fault_clr)                   conflict_cnt <= CNT_W'(1);
        else if (conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + CNT_W'(1);
      end else if (fault_clr) begin
        conflict_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_bus_mux.sv
// tb/tb_pipelined_bus_mux.sv - randomized self-checking bench for pipelined_bus_mux
module tb_pipelined_bus_mux;

`ifdef BUS_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         clear;
  logic [23:0]  sel;
  logic [767:0] data_in;
  logic         fault_clr;
  logic [31:0]  bus_out;
  logic         bus_valid;
  logic [5:0]   src_idx;
  logic         conflict;
  logic         fault;
  logic [7:0]   conflict_cnt;

  logic [7:0]   sel8;
  logic [127:0] data8;
  logic [15:0]  b8_out;
  logic         b8_valid;
  logic [2:0]   b8_idx;
  logic         b8_conf;
  logic         b8_fault;
  logic [7:0]   b8_cnt;

  logic [31:0]  m_bus;
  logic         m_valid;
  logic [5:0]   m_idx;
  logic         m_conf;
  logic         m_fault;
  int           m_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pipelined_bus_mux dut (
    .clock       (clock),
    .clear       (clear),
    .sel         (sel),
    .data_in     (data_in),
    .fault_clr   (fault_clr),
    .bus_out     (bus_out),
    .bus_valid   (bus_valid),
    .src_idx     (src_idx),
    .conflict    (conflict),
    .fault       (fault),
    .conflict_cnt(conflict_cnt)
  );

  pipelined_bus_mux #(.WIDTH(16), .N_SRC(8), .IDX_W(3), .CNT_W(8)) dut8 (
    .clock       (clock),
    .clear       (clear),
    .sel         (sel8),
    .data_in     (data8),
    .fault_clr   (fault_clr),
    .bus_out     (b8_out),
    .bus_valid   (b8_valid),
    .src_idx     (b8_idx),
    .conflict    (b8_conf),
    .fault       (b8_fault),
    .conflict_cnt(b8_cnt)
  );

  // Reference: apply the select rules to the inputs present before the coming edge.
  task automatic model_edge();
    int pc;
    int lo;
    pc = $countones(sel);
    lo = -1;
    for (int i = 0; i < 24; i++) if (sel[i] && lo < 0) lo = i;
    if (clear) begin
      m_bus = 0; m_valid = 0; m_idx = 0; m_conf = 0; m_fault = 0; m_cnt = 0;
    end else begin
      m_valid = (pc == 1);
      m_conf  = (pc >= 2);
      if (pc > 0) begin
        m_bus = data_in[lo*32 +: 32];
        m_idx = 6'(lo);
      end else if (!HOLD) begin
        m_bus = 0;
      end
      if (pc >= 2) begin
        m_cnt   = fault_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        m_fault = 1;
      end else if (fault_clr) begin
        m_cnt   = 0;
        m_fault = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [23:0] rand_multi();
    logic [23:0] s;
    int a;
    int b;
    a = $urandom_range(0, 23);
    b = (a + $urandom_range(1, 23)) % 24;
    s = 24'($urandom) | (24'd1 << a) | (24'd1 << b);
    return s;
  endfunction

  task automatic load_default_data();
    for (int i = 0; i < 24; i++) data_in[i*32 +: 32] = 32'hA000_0000 + 32'(i);
  endtask

  task automatic test_reset();
    clear = 1; fault_clr = 0; sel = 24'h000FF0; sel8 = 8'h0;
    tick();
    total++;
    if ({bus_out, bus_valid, src_idx, conflict, fault, conflict_cnt} !== 49'h0) begin
      bad++;
      $display("FAIL reset: got %h want 0", {bus_out, bus_valid, src_idx, conflict, fault, conflict_cnt});
    end
    total++;
    if ({b8_out, b8_valid, b8_idx, b8_conf, b8_fault, b8_cnt} !== 30'h0) begin
      bad++;
      $display("FAIL reset8: got %h want 0", {b8_out, b8_valid, b8_idx, b8_conf, b8_fault, b8_cnt});
    end
    clear = 0;
  endtask

  task automatic test_walk();
    for (int i = 0; i < 24; i++) begin
      sel = 24'd1 << i;
      tick();
      total++;
      if ({bus_out, src_idx, bus_valid, conflict} !== {32'hA000_0000 + 32'(i), 6'(i), 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL walk[%0d]: got bus=%h idx=%0d v=%b c=%b want bus=%h idx=%0d v=1 c=0",
                 i, bus_out, src_idx, bus_valid, conflict, 32'hA000_0000 + 32'(i), i);
      end
    end
  endtask

  task automatic test_multihot();
    sel = 24'h000014;
    tick();
    total++;
    if ({bus_out, src_idx, bus_valid, conflict, fault, conflict_cnt} !==
        {32'hA000_0002, 6'd2, 1'b0, 1'b1, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL multihot: got bus=%h idx=%0d v=%b c=%b f=%b cnt=%0d want A0000002 2 0 1 1 1",
               bus_out, src_idx, bus_valid, conflict, fault, conflict_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 300; k++) begin
      sel = rand_multi();
      tick();
      total++;
      if ({bus_out, bus_valid, src_idx, conflict, fault, conflict_cnt} !==
          {m_bus, m_valid, m_idx, m_conf, m_fault, 8'(m_cnt)}) begin
        bad++;
        $display("FAIL sat[%0d]: got bus=%h idx=%0d cnt=%0d want bus=%h idx=%0d cnt=%0d",
                 k, bus_out, src_idx, conflict_cnt, m_bus, m_idx, m_cnt);
      end
    end
    total++;
    if (conflict_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sat_cap: got %0d want 255", conflict_cnt);
    end
    sel = 24'd1 << 5; fault_clr = 1;
    tick();
    fault_clr = 0;
    total++;
    if ({conflict_cnt, fault, bus_out, bus_valid} !== {8'd0, 1'b0, 32'hA000_0005, 1'b1}) begin
      bad++;
      $display("FAIL sat_clr: got cnt=%0d f=%b bus=%h v=%b want 0 0 A0000005 1",
               conflict_cnt, fault, bus_out, bus_valid);
    end
  endtask

  task automatic test_zero_sel();
    logic [31:0] want;
    sel = 24'd1 << 7;
    tick();
    sel = 24'h0;
    tick();
    want = HOLD ? 32'hA000_0007 : 32'h0;
    total++;
    if ({bus_out, bus_valid, src_idx, conflict} !== {want, 1'b0, 6'd7, 1'b0}) begin
      bad++;
      $display("FAIL zero_sel: got bus=%h v=%b idx=%0d c=%b want bus=%h v=0 idx=7 c=0",
               bus_out, bus_valid, src_idx, conflict, want);
    end
  endtask

  task automatic test_clear_in_fault();
    sel = 24'h000003;
    tick();
    total++;
    if (fault !== 1'b1) begin
      bad++;
      $display("FAIL cif_pre: got fault=%b want 1", fault);
    end
    clear = 1; sel = 24'h00F000; fault_clr = 0;
    tick();
    clear = 0;
    total++;
    if ({bus_out, bus_valid, src_idx, conflict, fault, conflict_cnt} !== 49'h0) begin
      bad++;
      $display("FAIL cif_clear: got %h want 0", {bus_out, bus_valid, src_idx, conflict, fault, conflict_cnt});
    end
    sel = 24'd1 << 3;
    tick();
    total++;
    if ({bus_out, src_idx, bus_valid, fault} !== {32'hA000_0003, 6'd3, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL cif_after: got bus=%h idx=%0d v=%b f=%b want A0000003 3 1 0",
               bus_out, src_idx, bus_valid, fault);
    end
  endtask

  task automatic test_random();
    int kind;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 24; i++) data_in[i*32 +: 32] = $urandom;
      kind = $urandom_range(0, 3);
      case (kind)
        0:       sel = 24'h0;
        1:       sel = 24'd1 << $urandom_range(0, 23);
        2:       sel = rand_multi();
        default: sel = 24'($urandom);
      endcase
      fault_clr = ($urandom_range(0, 7) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      tick();
      total++;
      if ({bus_out, bus_valid, src_idx, conflict, fault, conflict_cnt} !==
          {m_bus, m_valid, m_idx, m_conf, m_fault, 8'(m_cnt)}) begin
        bad++;
        $display("FAIL rand[%0d]: got bus=%h v=%b idx=%0d c=%b f=%b cnt=%0d want bus=%h v=%b idx=%0d c=%b f=%b cnt=%0d",
                 k, bus_out, bus_valid, src_idx, conflict, fault, conflict_cnt,
                 m_bus, m_valid, m_idx, m_conf, m_fault, m_cnt);
      end
    end
    clear = 0; fault_clr = 0;
    load_default_data();
  endtask

  task automatic test_small();
    sel = 24'h0;
    for (int i = 0; i < 8; i++) data8[i*16 +: 16] = 16'hB000 + 16'(i * 17);
    for (int i = 0; i < 8; i++) begin
      sel8 = 8'd1 << i;
      tick();
      total++;
      if ({b8_out, b8_idx, b8_valid, b8_conf} !== {16'hB000 + 16'(i * 17), 3'(i), 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL small[%0d]: got bus=%h idx=%0d v=%b c=%b want bus=%h idx=%0d v=1 c=0",
                 i, b8_out, b8_idx, b8_valid, b8_conf, 16'hB000 + 16'(i * 17), i);
      end
    end
    sel8 = 8'b1010_0000;
    tick();
    total++;
    if ({b8_out, b8_idx, b8_valid, b8_conf, b8_fault} !== {16'hB000 + 16'(5 * 17), 3'd5, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL small_multi: got bus=%h idx=%0d v=%b c=%b f=%b want bus=%h idx=5 v=0 c=1 f=1",
               b8_out, b8_idx, b8_valid, b8_conf, b8_fault, 16'hB000 + 16'(5 * 17));
    end
    sel8 = 8'h0;
  endtask

  initial begin
    clear = 1; fault_clr = 0; sel = 0; sel8 = 0; data8 = 0;
    m_bus = 0; m_valid = 0; m_idx = 0; m_conf = 0; m_fault = 0; m_cnt = 0;
    load_default_data();
    @(posedge clock);
    #1;
    test_reset();
    test_walk();
    test_multihot();
    test_saturation();
    test_zero_sel();
    test_clear_in_fault();
    test_random();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
